alert_ping_scheduler: RTL and testbench

Periodic liveness checker for the alert and escalation signaling channels. It alternates ping requests between one alert receiver and one escalation sender, picking each target pseudo-randomly, and waits for the matching acknowledgement. A missing ack within a programmable timeout raises a failure pulse. It sits in the alert handler between the CSR configuration and the per-channel receiver/sender instances, which turn `*_ping_req_o` into differential ping traffic.

---
 rtl/alert_ping_scheduler.sv | 176 +++++++++++++++++
 tb/tb_alert_ping_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alert_ping_scheduler.sv
// Alternates liveness pings between one alert receiver and one escalation sender,
// choosing targets with a Galois LFSR and flagging a missing ack after a timeout.
module alert_ping_scheduler #(
    parameter int          NumAlerts = 4,
    parameter int          NumEsc    = 4,
    parameter int          WaitW     = 24,
    parameter int          TimeoutW  = 16,
    parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [NumAlerts-1:0] alert_en_i,
    input  logic [WaitW-1:0]     ping_wait_i,
    input  logic [TimeoutW-1:0]  timeout_i,
    output logic [NumAlerts-1:0] alert_ping_req_o,
    input  logic [NumAlerts-1:0] alert_ping_ack_i,
    output logic [NumEsc-1:0]    esc_ping_req_o,
    input  logic [NumEsc-1:0]    esc_ping_ack_i,
    output logic                 alert_ping_fail_o,
    output logic                 esc_ping_fail_o
);

    typedef enum logic [2:0] {
        Idle,
        AlertWait,
        AlertPing,
        EscWait,
        EscPing
    } state_e;

    localparam logic [15:0] LfsrMask = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LfsrMask : 16'h0000);
    endfunction

    function automatic logic [7:0] sel_idx(input logic [15:0] v, input int n);
        return 8'(32'(v[7:0]) % 32'(n));
    endfunction

    state_e                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d, lfsr_nxt;
    logic [7:0]            idx_q, idx_d;
    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [TimeoutW-1:0]   to_cnt_q, to_cnt_d;
    logic [NumAlerts-1:0]  alert_req_q, alert_req_d, alert_sel;
    logic [NumEsc-1:0]     esc_req_q, esc_req_d, esc_sel;
    logic                  alert_fail_q, alert_fail_d;
    logic                  esc_fail_q, esc_fail_d;
    logic                  enter_alert_wait, enter_esc_wait;

    assign lfsr_nxt = lfsr_step(lfsr_q);

    always_comb begin
        alert_sel = '0;
        for (int i = 0; i < NumAlerts; i++) alert_sel[i] = (idx_q == 8'(i));
        esc_sel = '0;
        for (int i = 0; i < NumEsc; i++) esc_sel[i] = (idx_q == 8'(i));
    end

    always_comb begin
        state_d          = state_q;
        lfsr_d           = lfsr_q;
        idx_d            = idx_q;
        wait_cnt_d       = wait_cnt_q;
        to_cnt_d         = to_cnt_q;
        alert_fail_d     = 1'b0;
        esc_fail_d       = 1'b0;
        enter_alert_wait = 1'b0;
        enter_esc_wait   = 1'b0;

        unique case (state_q)
            Idle: begin
                if (en_i) enter_alert_wait = 1'b1;
            end
            AlertWait: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else if (|(alert_en_i & alert_sel)) begin
                    state_d  = AlertPing;
                    to_cnt_d = '0;
                end else begin
                    enter_esc_wait = 1'b1;
                end
            end
            AlertPing: begin
                // An ack on the final window cycle wins over the timeout.
                if (|(alert_ping_ack_i & alert_sel)) begin
                    enter_esc_wait = 1'b1;
                end else if (to_cnt_q == timeout_i) begin
                    alert_fail_d   = 1'b1;
                    enter_esc_wait = 1'b1;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            EscWait: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    state_d  = EscPing;
                    to_cnt_d = '0;
                end
            end
            EscPing: begin
                if (|(esc_ping_ack_i & esc_sel)) begin
                    enter_alert_wait = 1'b1;
                end else if (to_cnt_q == timeout_i) begin
                    esc_fail_d       = 1'b1;
                    enter_alert_wait = 1'b1;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = Idle;
        endcase

        if (enter_alert_wait) begin
            state_d    = AlertWait;
            lfsr_d     = lfsr_nxt;
            idx_d      = sel_idx(lfsr_nxt, NumAlerts);
            wait_cnt_d = ping_wait_i;
        end
        if (enter_esc_wait) begin
            state_d    = EscWait;
            lfsr_d     = lfsr_nxt;
            idx_d      = sel_idx(lfsr_nxt, NumEsc);
            wait_cnt_d = ping_wait_i;
        end

        // Disabling mid-round abandons the ping silently and keeps the LFSR position.
        if (state_q != Idle && !en_i) begin
            state_d      = Idle;
            lfsr_d       = lfsr_q;
            idx_d        = idx_q;
            wait_cnt_d   = wait_cnt_q;
            to_cnt_d     = to_cnt_q;
            alert_fail_d = 1'b0;
            esc_fail_d   = 1'b0;
        end

        alert_req_d = (state_d == AlertPing) ? alert_sel : '0;
        esc_req_d   = (state_d == EscPing) ? esc_sel : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= Idle;
            lfsr_q       <= LfsrSeed;
            idx_q        <= '0;
            wait_cnt_q   <= '0;
            to_cnt_q     <= '0;
            alert_req_q  <= '0;
            esc_req_q    <= '0;
            alert_fail_q <= 1'b0;
            esc_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            idx_q        <= idx_d;
            wait_cnt_q   <= wait_cnt_d;
            to_cnt_q     <= to_cnt_d;
            alert_req_q  <= alert_req_d;
            esc_req_q    <= esc_req_d;
            alert_fail_q <= alert_fail_d;
            esc_fail_q   <= esc_fail_d;
        end
    end

    assign alert_ping_req_o  = alert_req_q;
    assign esc_ping_req_o    = esc_req_q;
    assign alert_ping_fail_o = alert_fail_q;
    assign esc_ping_fail_o   = esc_fail_q;

endmodule

// File: tb/tb_alert_ping_scheduler.sv
// Directed bench for alert_ping_scheduler with an LFSR reference model feeding
// a scoreboard of expected ping targets.
module tb_alert_ping_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  alert_en_i = 4'hF;
    logic [23:0] ping_wait_i = 24'd3;
    logic [15:0] timeout_i = 16'd10;
    logic [3:0]  alert_ping_ack_i = 4'h0;
    logic [3:0]  esc_ping_ack_i = 4'h0;
    logic [3:0]  alert_ping_req_o;
    logic [3:0]  esc_ping_req_o;
    logic        alert_ping_fail_o;
    logic        esc_ping_fail_o;

    alert_ping_scheduler #(
        .NumAlerts(4), .NumEsc(4), .WaitW(24), .TimeoutW(16), .LfsrSeed(16'hACE1)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .en_i(en_i),
        .alert_en_i(alert_en_i),
        .ping_wait_i(ping_wait_i),
        .timeout_i(timeout_i),
        .alert_ping_req_o(alert_ping_req_o),
        .alert_ping_ack_i(alert_ping_ack_i),
        .esc_ping_req_o(esc_ping_req_o),
        .esc_ping_ack_i(esc_ping_ack_i),
        .alert_ping_fail_o(alert_ping_fail_o),
        .esc_ping_fail_o(esc_ping_fail_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int af_cnt = 0;
    int ef_cnt = 0;

    always @(negedge clk) begin
        if (alert_ping_fail_o === 1'b1) af_cnt++;
        if (esc_ping_fail_o === 1'b1) ef_cnt++;
    end

    typedef struct {
        bit is_esc;
        int idx;
    } ping_t;
    ping_t sb[$];

    bit [15:0] m_lfsr;
    bit        m_esc_next;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [15:0] ref_lfsr(input bit [15:0] v);
        bit lsb;
        lsb = v[0];
        v = v >> 1;
        if (lsb) v = v ^ 16'hB400;
        return v;
    endfunction

    function automatic void model_reset();
        m_lfsr = 16'hACE1;
        m_esc_next = 1'b0;
        sb.delete();
    endfunction

    // Advance the model to the next round that actually pings; skipped alerts step the LFSR too.
    function automatic void model_push(input logic [3:0] aen);
        bit    done;
        int    idx;
        ping_t p;
        done = 1'b0;
        while (!done) begin
            m_lfsr = ref_lfsr(m_lfsr);
            idx = int'(m_lfsr[7:0]) % 4;
            if (!m_esc_next && aen[idx] !== 1'b1) begin
                m_esc_next = 1'b1;
            end else begin
                p.is_esc = m_esc_next;
                p.idx = idx;
                sb.push_back(p);
                m_esc_next = !m_esc_next;
                done = 1'b1;
            end
        end
    endfunction

    task automatic check_next(output logic [3:0] vec, output bit is_esc, output int lat);
        ping_t      e;
        logic [3:0] exp_vec;
        lat = 0;
        vec = 4'h0;
        is_esc = 1'b0;
        while ((alert_ping_req_o | esc_ping_req_o) == 4'h0 && lat < 200) begin
            step();
            lat++;
        end
        if (lat >= 200) begin
            chk("req_wait_timeout", 32'd1, 32'd0);
            return;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        is_esc = (esc_ping_req_o != 4'h0);
        vec = is_esc ? esc_ping_req_o : alert_ping_req_o;
        exp_vec = 4'(1 << e.idx);
        chk("both_req", 32'((alert_ping_req_o != 4'h0) && (esc_ping_req_o != 4'h0)), 32'd0);
        chk("kind", 32'(is_esc), 32'(e.is_esc));
        chk("onehot", 32'($onehot(vec)), 32'd1);
        chk("idx", 32'(vec), 32'(exp_vec));
    endtask

    task automatic ack_after(input bit is_esc, input logic [3:0] vec, input int delay);
        repeat (delay) step();
        if (is_esc) esc_ping_ack_i = vec;
        else alert_ping_ack_i = vec;
        step();
        alert_ping_ack_i = 4'h0;
        esc_ping_ack_i = 4'h0;
        chk("req_drop", 32'(is_esc ? esc_ping_req_o : alert_ping_req_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        en_i = 1'b0;
        alert_ping_ack_i = 4'h0;
        esc_ping_ack_i = 4'h0;
        step();
        step();
        chk("rst_alert_req", 32'(alert_ping_req_o), 32'd0);
        chk("rst_esc_req", 32'(esc_ping_req_o), 32'd0);
        chk("rst_fails", 32'({alert_ping_fail_o, esc_ping_fail_o}), 32'd0);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] vec;
        bit         is_esc;
        int         lat;
        int         held;
        int         af0, ef0;

        // Basic alternating pings, ack two cycles after each request.
        do_reset();
        alert_en_i = 4'hF;
        ping_wait_i = 24'd3;
        timeout_i = 16'd10;
        af0 = af_cnt;
        ef0 = ef_cnt;
        en_i = 1'b1;
        model_push(alert_en_i);
        for (int i = 0; i < 100; i++) begin
            check_next(vec, is_esc, lat);
            chk("kind_alternates", 32'(is_esc), 32'(i % 2));
            chk("wait_latency", 32'(lat), (i == 0) ? 32'd5 : 32'd4);
            ack_after(is_esc, vec, 2);
            model_push(alert_en_i);
        end
        chk("basic_alert_fails", 32'(af_cnt - af0), 32'd0);
        chk("basic_esc_fails", 32'(ef_cnt - ef0), 32'd0);

        // Alert timeout: alerts never acked, escalations acked at once.
        do_reset();
        timeout_i = 16'd5;
        af0 = af_cnt;
        ef0 = ef_cnt;
        en_i = 1'b1;
        model_push(alert_en_i);
        for (int r = 0; r < 2; r++) begin
            check_next(vec, is_esc, lat);
            held = 0;
            while (alert_ping_req_o != 4'h0 && held < 50) begin
                held++;
                step();
            end
            chk("timeout_req_width", 32'(held), 32'd6);
            chk("timeout_fail_pulse", 32'(alert_ping_fail_o), 32'd1);
            step();
            chk("timeout_fail_one_cycle", 32'(alert_ping_fail_o), 32'd0);
            model_push(alert_en_i);
            check_next(vec, is_esc, lat);
            ack_after(is_esc, vec, 0);
            model_push(alert_en_i);
        end
        chk("timeout_alert_fail_count", 32'(af_cnt - af0), 32'd2);
        chk("timeout_esc_fail_count", 32'(ef_cnt - ef0), 32'd0);

        // Ack on the last window cycle counts as success.
        do_reset();
        timeout_i = 16'd5;
        af0 = af_cnt;
        en_i = 1'b1;
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        ack_after(is_esc, vec, 5);
        step();
        step();
        chk("race_no_fail", 32'(af_cnt - af0), 32'd0);
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        chk("race_then_esc", 32'(is_esc), 32'd1);
        ack_after(is_esc, vec, 0);

        // Only alert 0 enabled, then no alerts at all.
        do_reset();
        timeout_i = 16'd10;
        alert_en_i = 4'b0001;
        af0 = af_cnt;
        ef0 = ef_cnt;
        en_i = 1'b1;
        model_push(alert_en_i);
        for (int i = 0; i < 20; i++) begin
            check_next(vec, is_esc, lat);
            if (!is_esc) chk("masked_alert_idx0", 32'(vec), 32'd1);
            ack_after(is_esc, vec, 0);
            model_push(alert_en_i);
        end
        do_reset();
        alert_en_i = 4'b0000;
        en_i = 1'b1;
        model_push(alert_en_i);
        for (int i = 0; i < 10; i++) begin
            check_next(vec, is_esc, lat);
            chk("esc_only", 32'(is_esc), 32'd1);
            ack_after(is_esc, vec, 1);
            model_push(alert_en_i);
        end
        chk("masked_alert_fails", 32'(af_cnt - af0), 32'd0);
        chk("masked_esc_fails", 32'(ef_cnt - ef0), 32'd0);

        // Abort while the escalation request is high, then resume.
        do_reset();
        alert_en_i = 4'hF;
        af0 = af_cnt;
        ef0 = ef_cnt;
        en_i = 1'b1;
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        ack_after(is_esc, vec, 1);
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        chk("abort_on_esc", 32'(is_esc), 32'd1);
        en_i = 1'b0;
        step();
        chk("abort_esc_clear", 32'(esc_ping_req_o), 32'd0);
        repeat (3) step();
        chk("abort_no_alert_fail", 32'(af_cnt - af0), 32'd0);
        chk("abort_no_esc_fail", 32'(ef_cnt - ef0), 32'd0);
        m_esc_next = 1'b0;
        sb.delete();
        en_i = 1'b1;
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        chk("resume_latency", 32'(lat), 32'd5);
        ack_after(is_esc, vec, 0);

        // Spurious ack on another line, then reset mid-ping.
        do_reset();
        en_i = 1'b1;
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        alert_ping_ack_i = ~vec & 4'hF;
        step();
        alert_ping_ack_i = 4'h0;
        chk("spurious_ack_ignored", 32'(alert_ping_req_o), 32'(vec));
        rst_ni = 1'b0;
        step();
        chk("midrst_alert_req", 32'(alert_ping_req_o), 32'd0);
        chk("midrst_esc_req", 32'(esc_ping_req_o), 32'd0);
        chk("midrst_fails", 32'({alert_ping_fail_o, esc_ping_fail_o}), 32'd0);
        chk("midrst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        rst_ni = 1'b1;
        model_reset();
        model_push(alert_en_i);
        check_next(vec, is_esc, lat);
        chk("post_rst_latency", 32'(lat), 32'd5);
        ack_after(is_esc, vec, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
